memory_responder: RTL and testbench

Byte-addressed RAM that is the responder end of the processor's memory handshake. The control unit drives MOV/RW/DL/SIG and waits for MOC; this block latches the request, inserts a fixed number of wait states, performs a big-endian byte, halfword or word access, asserts MOC, and holds it until the initiator drops MOV. It sits between the MAR/MDR registers of the data path and the system clock domain.

---
 rtl/memory_responder.sv | 205 ++++++++++++++++++++
 tb/tb_memory_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - byte-addressed big-endian RAM answering the MOV/MOC memory handshake
// Optional MEM_ALIGN_CHECK_EN: misaligned halfword/word accesses raise fault instead of being aligned down.
module memory_responder #(
  parameter int DEPTH_BYTES = 512,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MOV,
  input  logic        RW,
  input  logic [1:0]  DL,
  input  logic        SIG,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        MOC
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        fault
`endif
);

  localparam int AW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        state, state_n;
  logic [3:0]    cnt;
  logic          rw_q, sig_q;
  logic [1:0]    dl_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;

  logic [7:0]    mem [DEPTH_BYTES];

  logic          acc_rw, acc_sig;
  logic [1:0]    acc_dl;
  logic [AW-1:0] acc_raw, a0, a1, a2, a3;
  logic [31:0]   acc_wdata, rd_data;
  logic [7:0]    b0, b1, b2, b3;
  logic          fire, mem_we, moc_n;
  logic [31:0]   data_n;
`ifdef MEM_ALIGN_CHECK_EN
  logic          misalign, fault_n;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^address[31:AW];

  // With LATENCY=1 the access happens on the accept edge, so it must see the live inputs.
  always_comb begin
    if (state == S_IDLE) begin
      acc_rw    = RW;
      acc_dl    = DL;
      acc_sig   = SIG;
      acc_raw   = address[AW-1:0];
      acc_wdata = data_in;
    end else begin
      acc_rw    = rw_q;
      acc_dl    = dl_q;
      acc_sig   = sig_q;
      acc_raw   = addr_q;
      acc_wdata = wdata_q;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = ((acc_dl == 2'b01) && acc_raw[0]) ||
                    (acc_dl[1] && (acc_raw[1:0] != 2'b00));
  assign a0 = acc_raw;
`else
  always_comb begin
    a0 = acc_raw;
    if (acc_dl == 2'b01)
      a0 = {acc_raw[AW-1:1], 1'b0};
    else if (acc_dl[1])
      a0 = {acc_raw[AW-1:2], 2'b00};
  end
`endif

  assign a1 = a0 + AW'(1);
  assign a2 = a0 + AW'(2);
  assign a3 = a0 + AW'(3);

  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  always_comb begin
    case (acc_dl)
      2'b00:   rd_data = {{24{acc_sig & b0[7]}}, b0};
      2'b01:   rd_data = {{16{acc_sig & b0[7]}}, b0, b1};
      default: rd_data = {b0, b1, b2, b3};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (MOV) state_n = (LATENCY == 1) ? S_DONE : S_WAIT;
      S_WAIT: begin
        if (!MOV)
          state_n = S_IDLE;
        else if (cnt == 4'd0)
          state_n = S_DONE;
      end
      S_DONE: if (!MOV) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign fire = (state_n == S_DONE) && (state != S_DONE);

  always_comb begin
    moc_n  = MOC;
    data_n = data_out;
    mem_we = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    fault_n = fault;
`endif
    if (fire) begin
      moc_n = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
      if (misalign) begin
        fault_n = 1'b1;
        data_n  = '0;
      end else begin
        fault_n = 1'b0;
        if (acc_rw)
          data_n = rd_data;
        mem_we = !acc_rw;
      end
`else
      if (acc_rw)
        data_n = rd_data;
      mem_we = !acc_rw;
`endif
    end else if ((state == S_DONE) && !MOV) begin
      moc_n = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      fault_n = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      rw_q     <= 1'b0;
      dl_q     <= '0;
      sig_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      MOC      <= 1'b0;
      data_out <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      fault    <= 1'b0;
`endif
    end else begin
      if ((state == S_IDLE) && MOV) begin
        rw_q    <= RW;
        dl_q    <= DL;
        sig_q   <= SIG;
        addr_q  <= address[AW-1:0];
        wdata_q <= data_in;
        cnt     <= 4'(LATENCY - 1);
      end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      MOC      <= moc_n;
      data_out <= data_n;
`ifdef MEM_ALIGN_CHECK_EN
      fault    <= fault_n;
`endif
    end
  end

  // Storage is not reset; gating on reset keeps a write from committing on an edge where reset is held.
  always_ff @(posedge clk) begin
    if (mem_we && reset) begin
      case (acc_dl)
        2'b00: mem[a0] <= acc_wdata[7:0];
        2'b01: begin
          mem[a0] <= acc_wdata[15:8];
          mem[a1] <= acc_wdata[7:0];
        end
        default: begin
          mem[a0] <= acc_wdata[31:24];
          mem[a1] <= acc_wdata[23:16];
          mem[a2] <= acc_wdata[15:8];
          mem[a3] <= acc_wdata[7:0];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// tb/tb_memory_responder.sv - scoreboard bench for memory_responder (MEM_ALIGN_CHECK_EN aware)
module tb_memory_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MOV = 1'b0;
  logic        RW = 1'b0;
  logic [1:0]  DL = 2'b00;
  logic        SIG = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        MOC;
`ifdef MEM_ALIGN_CHECK_EN
  logic        fault;
`endif

  memory_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .MOV(MOV), .RW(RW), .DL(DL), .SIG(SIG),
    .address(address), .data_in(data_in), .data_out(data_out), .MOC(MOC)
`ifdef MEM_ALIGN_CHECK_EN
    , .fault(fault)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          moc_cyc;
    logic [31:0] data;
    logic        flt;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per MOC rise and checks stability while MOC is held.
  initial begin
    logic        moc_prev;
    logic [31:0] held;
    exp_t        e;
    moc_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (MOC && !moc_prev) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_moc: got MOC=1 want no response at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          check({e.name, "_latency"}, cyc, e.moc_cyc);
          check({e.name, "_data"}, data_out, e.data);
`ifdef MEM_ALIGN_CHECK_EN
          check({e.name, "_fault"}, {31'b0, fault}, {31'b0, e.flt});
`endif
        end
        held = data_out;
      end else if (MOC && moc_prev) begin
        check("hold_stable", data_out, held);
      end
      moc_prev = MOC;
    end
  end

  task automatic req(input string name, input logic rw, input logic [1:0] dl, input logic sig,
                     input logic [31:0] addr, input logic [31:0] din, input logic [31:0] exp,
                     input logic flt, input int hold);
    exp_t e;
    int   n;
    @(negedge clk);
    RW = rw; DL = dl; SIG = sig; address = addr; data_in = din; MOV = 1'b1;
    e.moc_cyc = cyc + 1 + LAT;
    e.name = name;
    e.flt = flt;
    if (flt)
      last_data = '0;
    else if (rw)
      last_data = exp;
    e.data = last_data;
    sb.push_back(e);
    n = 0;
    while (!MOC && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!MOC) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no MOC within 40 cycles want MOC=1", name);
      MOV = 1'b0;
      void'(sb.pop_back());
      return;
    end
    repeat (hold) @(negedge clk);
    MOV = 1'b0;
    @(negedge clk);
    check({name, "_moc_fall"}, {31'b0, MOC}, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
    check({name, "_fault_clear"}, {31'b0, fault}, 32'd0);
`endif
  endtask

  task automatic abort_write(input logic [31:0] addr, input logic [31:0] din);
    logic seen;
    @(negedge clk);
    RW = 1'b0; DL = 2'b10; SIG = 1'b0; address = addr; data_in = din; MOV = 1'b1;
    @(negedge clk);
    MOV = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (MOC) seen = 1'b1;
    end
    check("abort_no_moc", {31'b0, seen}, 32'd0);
  endtask

  task automatic reset_mid_write(input logic [31:0] addr, input logic [31:0] din);
    @(negedge clk);
    RW = 1'b0; DL = 2'b10; SIG = 1'b0; address = addr; data_in = din; MOV = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    MOV = 1'b0;
    #1;
    check("rst_mid_moc", {31'b0, MOC}, 32'd0);
    check("rst_mid_data", data_out, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    last_data = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_moc", {31'b0, MOC}, 32'd0);
    check("reset_data", data_out, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
    check("reset_fault", {31'b0, fault}, 32'd0);
`endif
    reset = 1'b1;

    req("wr_word",   1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 0);
    req("rd_word",   1'b1, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 0);
    req("rd_b10",    1'b1, 2'b00, 1'b0, 32'h10, 32'h0,        32'h000000DE, 1'b0, 0);
    req("rd_b13_s",  1'b1, 2'b00, 1'b1, 32'h13, 32'h0,        32'hFFFFFFEF, 1'b0, 0);
    req("rd_b13_u",  1'b1, 2'b00, 1'b0, 32'h13, 32'h0,        32'h000000EF, 1'b0, 0);
    req("wr_half",   1'b0, 2'b01, 1'b0, 32'h12, 32'hFFFF1234, 32'h0,        1'b0, 0);
    req("rd_merge",  1'b1, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEAD1234, 1'b0, 0);
    req("rd_half_s", 1'b1, 2'b01, 1'b1, 32'h10, 32'h0,        32'hFFFFDEAD, 1'b0, 0);
    req("rd_hold",   1'b1, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEAD1234, 1'b0, 5);

    req("wr_20",     1'b0, 2'b10, 1'b0, 32'h20, 32'h55AA55AA, 32'h0,        1'b0, 0);
    abort_write(32'h20, 32'h11111111);
    req("rd_abort",  1'b1, 2'b10, 1'b0, 32'h20, 32'h0,        32'h55AA55AA, 1'b0, 0);
    reset_mid_write(32'h20, 32'h22222222);
    req("rd_rst",    1'b1, 2'b10, 1'b0, 32'h20, 32'h0,        32'h55AA55AA, 1'b0, 0);

    req("wr_byte",   1'b0, 2'b00, 1'b0, 32'h23, 32'hFFFFFF77, 32'h0,        1'b0, 0);
    req("rd_byte_m", 1'b1, 2'b10, 1'b0, 32'h20, 32'h0,        32'h55AA5577, 1'b0, 0);

    req("wr_wrap",   1'b0, 2'b10, 1'b0, DEPTH + 4, 32'hCAFEF00D, 32'h0,     1'b0, 0);
    req("rd_wrap",   1'b1, 2'b11, 1'b0, 32'h4,  32'h0,        32'hCAFEF00D, 1'b0, 0);

`ifdef MEM_ALIGN_CHECK_EN
    req("rd_mis_w",  1'b1, 2'b10, 1'b0, 32'h11, 32'h0,        32'h0,        1'b1, 0);
    req("rd_mis_h",  1'b1, 2'b01, 1'b0, 32'h13, 32'h0,        32'h0,        1'b1, 0);
    req("wr_mis_w",  1'b0, 2'b10, 1'b0, 32'h11, 32'h99999999, 32'h0,        1'b1, 0);
    req("rd_after",  1'b1, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEAD1234, 1'b0, 0);
`else
    req("rd_mis_w",  1'b1, 2'b10, 1'b0, 32'h11, 32'h0,        32'hDEAD1234, 1'b0, 0);
    req("rd_mis_h",  1'b1, 2'b01, 1'b0, 32'h13, 32'h0,        32'h00001234, 1'b0, 0);
`endif

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
